// File: rtl/serial_subtractor_a34_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Both sides use valid/ready: a transfer happens on the rising edge where valid and ready are both high.
interface serial_subtractor_a34_if #(
  parameter int SIZE = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            borrow_in;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] diff;
  logic            borrow_out;
  logic            ovf;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, ovf
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, ovf
  );
endinterface

// File: rtl/serial_subtractor_a34.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, LSB first,
// one full-subtractor cell plus a borrow flop, one operation in flight.
module serial_subtractor_a34 #(
   parameter int SIZE = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   serial_subtractor_a34_if.slave   bus,
   output logic [1:0]               dbg_state
);

   localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] sa_q, sb_q, res_q;
   logic            br_q;
   logic            a_msb_q, b_msb_q;
   logic [CW-1:0]   count_q;

   logic            accept, retire, last_bit;
   logic            a0, b0, d_bit, br_next;

   // Operands transfer on in_valid & in_ready; results retire on out_valid & out_ready.
   assign accept   = (state_q == IDLE) && bus.in_valid;
   assign retire   = (state_q == DONE) && bus.out_ready;
   assign last_bit = (count_q == CW'(SIZE - 1));

   // Full-subtractor cell
   assign a0      = sa_q[0];
   assign b0      = sb_q[0];
   assign d_bit   = a0 ^ b0 ^ br_q;
   assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)   state_d = CALC;
         CALC:    if (last_bit) state_d = DONE;
         DONE:    if (retire)   state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  sa_q    <= bus.a;
                  sb_q    <= bus.b;
                  br_q    <= bus.borrow_in;
                  a_msb_q <= bus.a[SIZE-1];
                  b_msb_q <= bus.b[SIZE-1];
                  count_q <= '0;
               end
            end
            CALC: begin
               sa_q    <= sa_q >> 1;
               sb_q    <= sb_q >> 1;
               res_q   <= {d_bit, res_q[SIZE-1:1]};
               br_q    <= br_next;
               // count returns to zero only by finishing the final bit
               count_q <= last_bit ? '0 : count_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // diff keeps the last result in IDLE; borrow/overflow are only driven while presenting
   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.diff       = res_q;
   assign bus.borrow_out = (state_q == DONE) & br_q;
   assign bus.ovf        = (state_q == DONE) & (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_q[SIZE-1]);
   assign dbg_state      = state_q;

endmodule
